// File: rtl/frame_sequencer.sv
// Runs a programmable number of fixed-length frames and emits per-frame
// programmable trigger pulses, with a start/busy/done handshake, stall and abort.
module frame_sequencer #(
    parameter int CNT_W  = 8,
    parameter int PERIOD = 91,
    parameter int N_TAP  = 4,
    parameter int IT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   en,
    input  logic [IT_W-1:0]        iters,
    input  logic [N_TAP*CNT_W-1:0] tap_at,
    output logic [CNT_W-1:0]       count,
    output logic [IT_W-1:0]        frame_idx,
    output logic [N_TAP-1:0]       tap_pulse,
    output logic                   frame_start,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(PERIOD - 1);

    state_t                   state_q;
    logic [CNT_W-1:0]         count_q;
    logic [IT_W-1:0]          frameIdx_q;
    logic [N_TAP-1:0]         tapPulse_q;
    logic                     frameStart_q;
    logic                     busy_q;
    logic                     done_q;
    logic [IT_W-1:0]          iters_q;
    logic [N_TAP*CNT_W-1:0]   tapAt_q;

    logic [N_TAP-1:0]         tapHit_d;
    logic                     atLast_d;
    logic                     finalFrame_d;

    always_comb begin
        tapHit_d = '0;
        for (int i = 0; i < N_TAP; i++) begin
            tapHit_d[i] = (count_q == tapAt_q[i*CNT_W +: CNT_W]);
        end
    end

    // A latched iteration count of zero means run until aborted.
    assign atLast_d     = (count_q == LAST_COUNT);
    assign finalFrame_d = (iters_q != '0) && (frameIdx_q == (iters_q - 1'b1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            frameIdx_q   <= '0;
            tapPulse_q   <= '0;
            frameStart_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            iters_q      <= '0;
            tapAt_q      <= '0;
        end else begin
            tapPulse_q   <= '0;
            frameStart_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q      <= RUN;
                        busy_q       <= 1'b1;
                        iters_q      <= iters;
                        tapAt_q      <= tap_at;
                        count_q      <= '0;
                        frameIdx_q   <= '0;
                        frameStart_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        count_q    <= '0;
                        frameIdx_q <= '0;
                    end else if (en) begin
                        tapPulse_q <= tapHit_d;
                        if (atLast_d) begin
                            count_q <= '0;
                            if (finalFrame_d) begin
                                state_q    <= DONE;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                frameIdx_q <= '0;
                            end else begin
                                frameIdx_q   <= frameIdx_q + 1'b1;
                                frameStart_q <= 1'b1;
                            end
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign count       = count_q;
    assign frame_idx   = frameIdx_q;
    assign tap_pulse   = tapPulse_q;
    assign frame_start = frameStart_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Drives three differently parameterised sequencers in lockstep and compares
// every output, every cycle, against a position-based reference model.
module tb_frame_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, en;
    logic [7:0]  iters;
    logic [31:0] tapAt;

    logic [7:0]  cntO [3];
    logic [3:0]  tapO [3];
    logic        fsO [3];
    logic        busyO [3];
    logic        doneO [3];
    logic [7:0]  fiA, fiC;
    logic [3:0]  fiB;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is described only by how many enabled steps it has taken.
    bit       mRun [3];
    bit       mDone [3];
    int       mPos [3];
    int       mIt [3];
    int       mTap [3][4];
    bit [3:0] mTapP [3];
    bit       mFs [3];

    always #5 clk = ~clk;

    frame_sequencer #(.CNT_W(8), .PERIOD(91), .N_TAP(4), .IT_W(8)) dutA (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en),
        .iters(iters), .tap_at(tapAt), .count(cntO[0]), .frame_idx(fiA),
        .tap_pulse(tapO[0]), .frame_start(fsO[0]), .busy(busyO[0]), .done(doneO[0])
    );

    frame_sequencer #(.CNT_W(8), .PERIOD(4), .N_TAP(4), .IT_W(4)) dutB (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en),
        .iters(iters[3:0]), .tap_at(tapAt), .count(cntO[1]), .frame_idx(fiB),
        .tap_pulse(tapO[1]), .frame_start(fsO[1]), .busy(busyO[1]), .done(doneO[1])
    );

    frame_sequencer #(.CNT_W(8), .PERIOD(2), .N_TAP(4), .IT_W(8)) dutC (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .en(en),
        .iters(iters), .tap_at(tapAt), .count(cntO[2]), .frame_idx(fiC),
        .tap_pulse(tapO[2]), .frame_start(fsO[2]), .busy(busyO[2]), .done(doneO[2])
    );

    function automatic int perOf(int k);
        case (k)
            0:       return 91;
            1:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int modOf(int k);
        return (k == 1) ? 16 : 256;
    endfunction

    function automatic logic [31:0] frameOf(int k);
        case (k)
            0:       return 32'(fiA);
            1:       return 32'(fiB);
            default: return 32'(fiC);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mRun[k]  = 1'b0;
            mDone[k] = 1'b0;
            mPos[k]  = 0;
            mIt[k]   = 0;
            mTapP[k] = '0;
            mFs[k]   = 1'b0;
            for (int i = 0; i < 4; i++) mTap[k][i] = 0;
        end
    endtask

    task automatic modelStep();
        for (int k = 0; k < 3; k++) begin
            mTapP[k] = '0;
            mFs[k]   = 1'b0;
            if (mDone[k]) begin
                mDone[k] = 1'b0;
            end else if (mRun[k]) begin
                if (abort) begin
                    mRun[k] = 1'b0;
                    mPos[k] = 0;
                end else if (en) begin
                    for (int i = 0; i < 4; i++)
                        mTapP[k][i] = ((mPos[k] % perOf(k)) == mTap[k][i]);
                    mPos[k]++;
                    if (mIt[k] != 0 && mPos[k] == mIt[k] * perOf(k)) begin
                        mRun[k]  = 1'b0;
                        mDone[k] = 1'b1;
                        mPos[k]  = 0;
                    end else begin
                        mFs[k] = ((mPos[k] % perOf(k)) == 0);
                    end
                end
            end else if (start && !abort) begin
                mRun[k] = 1'b1;
                mPos[k] = 0;
                mFs[k]  = 1'b1;
                mIt[k]  = int'(iters) % modOf(k);
                for (int i = 0; i < 4; i++) mTap[k][i] = int'(tapAt[i*8 +: 8]);
            end
        end
    endtask

    task automatic checkAll();
        for (int k = 0; k < 3; k++) begin
            int ec;
            int ef;
            ec = mRun[k] ? (mPos[k] % perOf(k)) : 0;
            ef = mRun[k] ? ((mPos[k] / perOf(k)) % modOf(k)) : 0;
            checkOutput($sformatf("i%0d count", k), 32'(cntO[k]), ec);
            checkOutput($sformatf("i%0d frame_idx", k), frameOf(k), ef);
            checkOutput($sformatf("i%0d tap_pulse", k), 32'(tapO[k]), 32'(mTapP[k]));
            checkOutput($sformatf("i%0d frame_start", k), 32'(fsO[k]), 32'(mFs[k]));
            checkOutput($sformatf("i%0d busy", k), 32'(busyO[k]), 32'(mRun[k]));
            checkOutput($sformatf("i%0d done", k), 32'(doneO[k]), 32'(mDone[k]));
        end
    endtask

    task automatic applyStimulus(input bit s, input bit a, input bit e);
        start = s;
        abort = a;
        en    = e;
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
    endtask

    // Reset lands between edges so the outputs must clear with no clock.
    task automatic asyncReset();
        #2 rst = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        rst = 1'b1;
    endtask

    task automatic runToDone(input bit stall, input int expCycles);
        int cyc;
        int nTap [4] = '{0, 0, 0, 0};
        bit stalled = 1'b0;
        bit seen = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        cyc = 1;
        while (cyc < 400 && !seen) begin
            if (stall && !stalled && cntO[0] == 8'd10) begin
                for (int j = 0; j < 3; j++) begin
                    applyStimulus(1'b0, 1'b0, 1'b0);
                    checkOutput("stall count", 32'(cntO[0]), 10);
                    checkOutput("stall taps", 32'(tapO[0]), 0);
                end
                cyc += 3;
                stalled = 1'b1;
            end
            applyStimulus(1'b0, 1'b0, 1'b1);
            cyc++;
            for (int i = 0; i < 4; i++) if (tapO[0][i]) nTap[i]++;
            if (doneO[0]) begin
                seen = 1'b1;
                checkOutput("tap3 with done", 32'(tapO[0][3]), 1);
            end
        end
        checkOutput("done latency", cyc, expCycles);
        checkOutput("tap0 pulses", nTap[0], 2);
        checkOutput("tap1 pulses", nTap[1], 2);
        checkOutput("tap2 pulses", nTap[2], 0);
        checkOutput("tap3 pulses", nTap[3], 2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("busy after done", 32'(busyO[0]), 0);
    endtask

    function automatic logic [7:0] randTap();
        return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 100));
    endfunction

    initial begin
        int nDone;
        int guard;
        rst = 1'b1; start = 1'b0; abort = 1'b0; en = 1'b0;
        iters = '0; tapAt = '0;
        modelReset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Two-frame run, then the same run with a three-cycle stall at count 10.
        iters = 8'd2;
        tapAt = {8'd90, 8'd200, 8'd4, 8'd0};
        runToDone(1'b0, 183);
        runToDone(1'b1, 186);

        // Continuous mode long enough for the 4-bit frame index to wrap, then abort.
        iters = 8'd0;
        tapAt = {randTap(), randTap(), randTap(), randTap()};
        nDone = 0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 70; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) if (doneO[k]) nDone++;
        end
        guard = 0;
        while (cntO[1] != 8'd2 && guard < 8) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            guard++;
        end
        checkOutput("reach count 2", 32'(cntO[1]), 2);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort busy", 32'(busyO[1]), 0);
        checkOutput("abort count", 32'(cntO[1]), 0);
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 3; k++) if (doneO[k]) nDone++;
        end
        checkOutput("continuous done", nDone, 0);

        // Start mid-run with new taps must not re-latch.
        iters = 8'd1;
        tapAt = {8'd90, 8'd200, 8'd4, 8'd0};
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b1);
        tapAt = {8'd7, 8'd8, 8'd9, 8'd30};
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (75) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("start+abort idle", 32'(busyO[0]), 0);

        // Asynchronous reset at count 50, then a clean restart.
        iters = 8'd3;
        applyStimulus(1'b1, 1'b0, 1'b1);
        guard = 0;
        while (cntO[0] != 8'd50 && guard < 60) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            guard++;
        end
        checkOutput("reach count 50", 32'(cntO[0]), 50);
        asyncReset();
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("restart count", 32'(cntO[0]), 0);
        checkOutput("restart frame", 32'(fiA), 0);
        checkOutput("restart busy", 32'(busyO[0]), 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Shortest legal period: tap at the last count coincides with done.
        iters = 8'd1;
        tapAt = {8'd90, 8'd200, 8'd4, 8'd1};
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("p2 count", 32'(cntO[2]), 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("p2 done", 32'(doneO[2]), 1);
        checkOutput("p2 tap0", 32'(tapO[2][0]), 1);
        repeat (100) applyStimulus(1'b0, 1'b0, 1'b1);

        // Randomised traffic across all three instances.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                asyncReset();
            end else begin
                if ($urandom_range(0, 15) == 0) begin
                    iters = 8'($urandom_range(0, 3));
                    tapAt = {randTap(), randTap(), randTap(), randTap()};
                end
                applyStimulus($urandom_range(0, 5) == 0, $urandom_range(0, 39) == 0,
                              $urandom_range(0, 3) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
